fir_mac_serial: RTL

//  Parametrised single-clock serial-MAC FIR engine, successor to the fixed 64-tap ALU.

---
 rtl/fir_mac_serial_if.sv | 30 +++
 rtl/fir_mac_serial.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_serial_if.sv
// Handshake bundle for the serial-MAC FIR engine: coefficient load port,
// sample input port and filtered output port.
interface fir_mac_serial_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int OW = 16
);
    logic          coef_load;
    logic          coef_valid;
    logic [CW-1:0] coef_data;
    logic          coef_ready;
    logic          coef_done;
    logic          x_valid;
    logic [DW-1:0] x_data;
    logic          x_ready;
    logic          y_valid;
    logic [OW-1:0] y_data;
    logic          y_sat;
    logic          busy;

    modport slave (
        input  coef_load, coef_valid, coef_data, x_valid, x_data,
        output coef_ready, coef_done, x_ready, y_valid, y_data, y_sat, busy
    );

    modport master (
        output coef_load, coef_valid, coef_data, x_valid, x_data,
        input  coef_ready, coef_done, x_ready, y_valid, y_data, y_sat, busy
    );
endinterface

// File: rtl/fir_mac_serial.sv
// Serial-MAC FIR engine: loads TAPS coefficients, then filters each accepted
// sample with one multiply-accumulate per cycle, rounding and saturating the result.
module fir_mac_serial #(
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int TAPS      = 64,
    parameter int ACCW      = 40,
    parameter int OUT_SHIFT = 15,
    parameter int OW        = 16
) (
    input  logic                  clk,
    input  logic                  fir_rest,
    fir_mac_serial_if.slave       bus
);
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);
    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND   = ACCW'(1) <<< (OUT_SHIFT - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           r_m;
    logic signed [CW-1:0]    r_coef [TAPS];
    logic signed [DW-1:0]    r_dly  [TAPS];
    logic signed [ACCW-1:0]  r_acc;
    logic                    r_coef_done;
    logic                    r_y_valid;
    logic [OW-1:0]           r_y_data;
    logic                    r_y_sat;

    logic signed [DW+CW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  w_rounded;
    logic signed [ACCW-1:0]  w_shifted;
    logic [OW-1:0]           w_y_data;
    logic                    w_y_sat;
    logic                    w_coef_ready;
    logic                    w_x_ready;
    logic                    w_busy;

    assign w_prod     = r_dly[r_m] * r_coef[r_m];
    assign w_prod_ext = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
    assign w_rounded  = r_acc + RND;
    assign w_shifted  = w_rounded >>> OUT_SHIFT;

    // State register
    always_ff @(posedge clk) begin
        if (fir_rest) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an accepted sample takes priority over a reload request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (bus.coef_valid && (r_idx == LAST_IDX)) begin
                    w_next_state = ST_READY;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_READY: begin
                if (bus.x_valid) begin
                    w_next_state = ST_MAC;
                end else if (bus.coef_load) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_READY;
                end
            end
            ST_MAC: begin
                if (r_m == LAST_IDX) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_MAC;
                end
            end
            ST_OUT:  w_next_state = ST_READY;
            default: w_next_state = ST_LOAD;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        w_coef_ready = 1'b0;
        w_x_ready    = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_LOAD:  w_coef_ready = 1'b1;
            ST_READY: w_x_ready    = 1'b1;
            ST_MAC:   w_busy       = 1'b1;
            ST_OUT:   w_busy       = 1'b1;
            default:  w_coef_ready = 1'b0;
        endcase
    end

    // Round-half-up result clipped to the signed output range
    always_comb begin
        w_y_data = w_shifted[OW-1:0];
        w_y_sat  = 1'b0;
        if (w_shifted > Y_MAX) begin
            w_y_data = Y_MAX[OW-1:0];
            w_y_sat  = 1'b1;
        end else if (w_shifted < Y_MIN) begin
            w_y_data = Y_MIN[OW-1:0];
            w_y_sat  = 1'b1;
        end else begin
            w_y_data = w_shifted[OW-1:0];
            w_y_sat  = 1'b0;
        end
    end

    // Datapath: coefficient store, delay line, accumulator and output registers
    always_ff @(posedge clk) begin
        if (fir_rest) begin
            r_idx       <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_coef_done <= 1'b0;
            r_y_valid   <= 1'b0;
            r_y_data    <= '0;
            r_y_sat     <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
                r_dly[k]  <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (bus.coef_valid) begin
                        r_coef[r_idx] <= bus.coef_data;
                        r_idx         <= r_idx + IW'(1);
                        if (r_idx == LAST_IDX) begin
                            r_coef_done <= 1'b1;
                        end else begin
                            r_coef_done <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_READY: begin
                    if (bus.x_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_dly[k] <= r_dly[k-1];
                        end
                        r_dly[0] <= bus.x_data;
                        r_acc    <= '0;
                        r_m      <= '0;
                    end else if (bus.coef_load) begin
                        r_coef_done <= 1'b0;
                        r_idx       <= '0;
                    end else begin
                        r_m <= r_m;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_m   <= r_m + IW'(1);
                end
                ST_OUT: begin
                    r_y_valid <= 1'b1;
                    r_y_data  <= w_y_data;
                    r_y_sat   <= w_y_sat;
                end
                default: begin
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coef_ready = w_coef_ready;
    assign bus.coef_done  = r_coef_done;
    assign bus.x_ready    = w_x_ready;
    assign bus.busy       = w_busy;
    assign bus.y_valid    = r_y_valid;
    assign bus.y_data     = r_y_data;
    assign bus.y_sat      = r_y_sat;
endmodule
